reg_file_sb: RTL and testbench

Parametrised register file with three read ports, one write port, a program-counter register that auto-increments, and a per-register scoreboard of pending writes. It is the next-generation register bank for the ARM datapath: operand fetch reads Rn/Rm/Rs in one cycle, write-back drives the single write port, and the issue stage uses the scoreboard hazard flag to stall.

---
 rtl/reg_file_sb.sv | 68 ++++++
 tb/tb_reg_file_sb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: 3-read/1-write register file with auto-incrementing PC and pending-write scoreboard
// Ports: clk; clr (async, active-low reset); LE (active-low write enable), Rc/I (write index/data);
//   Ra/Rb/Rd -> Y0/Y1/Y2 combinational reads; pc_inc advances PC (index NREGS-1) by PC_STEP, pc_out shows it;
//   issue/issue_rd mark a destination pending in busy; hazard flags a pending read index.
// Option: REGFILE_BYPASS_EN makes a read of the index being written return I and drop out of hazard.
module reg_file_sb #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int AW      = 4,
  parameter int PC_STEP = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             LE,
  input  logic [AW-1:0]    Rc,
  input  logic [WIDTH-1:0] I,
  input  logic [AW-1:0]    Ra,
  input  logic [AW-1:0]    Rb,
  input  logic [AW-1:0]    Rd,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] pc_out,
  input  logic             issue,
  input  logic [AW-1:0]    issue_rd,
  output logic [NREGS-1:0] busy,
  output logic             hazard
);
  localparam logic [AW-1:0] PCI = AW'(NREGS - 1);
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             we;
  logic [2:0]       byp;
  assign we = !LE;
  // The write is applied after the increment so an explicit PC write wins;
  // issue is applied after the clear so a new producer keeps the bit set.
  always_comb begin
    regs_d = regs_q;
    if (pc_inc) regs_d[PCI] = regs_q[PCI] + WIDTH'(PC_STEP);
    if (we) regs_d[Rc] = I;
    busy_d = busy_q;
    if (we) busy_d[Rc] = 1'b0;
    if (issue) busy_d[issue_rd] = 1'b1;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign byp = {we && (Rd == Rc), we && (Rb == Rc), we && (Ra == Rc)};
`else
  assign byp = '0;
`endif
  assign Y0     = byp[0] ? I : regs_q[Ra];
  assign Y1     = byp[1] ? I : regs_q[Rb];
  assign Y2     = byp[2] ? I : regs_q[Rd];
  assign pc_out = regs_q[PCI];
  assign busy   = busy_q;
  // A port being written through this cycle is not waiting on anything.
  assign hazard = (busy_q[Ra] & ~byp[0]) | (busy_q[Rb] & ~byp[1]) | (busy_q[Rd] & ~byp[2]);
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        le = 1'b1, pinc = 1'b0, iss = 1'b0;
  logic [3:0]  rc = '0, ra = '0, rb = '0, rdx = '0, ird = '0;
  logic [31:0] wd = '0;
  logic [31:0] y0, y1, y2, pc;
  logic [15:0] bz;
  logic        hz;
  logic        s_le = 1'b1, s_pinc = 1'b0, s_iss = 1'b0;
  logic [2:0]  s_rc = '0, s_ra = '0, s_ird = '0;
  logic [15:0] s_wd = '0;
  logic [15:0] s_y0, s_y1, s_y2, s_pc;
  logic [7:0]  s_bz;
  logic        s_hz;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .clr(clr), .LE(le), .Rc(rc), .I(wd), .Ra(ra), .Rb(rb), .Rd(rdx),
    .Y0(y0), .Y1(y1), .Y2(y2), .pc_inc(pinc), .pc_out(pc), .issue(iss),
    .issue_rd(ird), .busy(bz), .hazard(hz)
  );

  reg_file_sb #(.WIDTH(16), .NREGS(8), .AW(3), .PC_STEP(2)) dut_s (
    .clk(clk), .clr(clr), .LE(s_le), .Rc(s_rc), .I(s_wd), .Ra(s_ra), .Rb(s_ra), .Rd(s_ra),
    .Y0(s_y0), .Y1(s_y1), .Y2(s_y2), .pc_inc(s_pinc), .pc_out(s_pc), .issue(s_iss),
    .issue_rd(s_ird), .busy(s_bz), .hazard(s_hz)
  );

  typedef struct {
    logic        le;
    logic [3:0]  rc;
    logic [31:0] i;
    logic [3:0]  ra, rb, rd;
    logic        pinc, iss;
    logic [3:0]  ird;
    logic [31:0] y0, y1, y2, pc;
    logic [15:0] bz;
    logic        hz;
  } vec_t;

  vec_t v [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //        le rc  i             ra  rb  rd  pinc iss ird  y0            y1            y2            pc            busy      hz
    v[0]  = '{0, 5,  32'h12345678, 5,  5,  5,  0,   0,  0,   32'h12345678, 32'h12345678, 32'h12345678, 32'h0,        16'h0000, 0};
    v[1]  = '{1, 0,  32'h0,        15, 5,  0,  1,   0,  0,   32'h4,        32'h12345678, 32'h0,        32'h4,        16'h0000, 0};
    v[2]  = '{1, 0,  32'h0,        15, 15, 15, 1,   0,  0,   32'h8,        32'h8,        32'h8,        32'h8,        16'h0000, 0};
    v[3]  = '{1, 0,  32'h0,        15, 0,  0,  1,   0,  0,   32'hC,        32'h0,        32'h0,        32'hC,        16'h0000, 0};
    v[4]  = '{1, 0,  32'h0,        7,  0,  0,  0,   1,  7,   32'h0,        32'h0,        32'h0,        32'hC,        16'h0080, 1};
    v[5]  = '{0, 7,  32'hA5A5A5A5, 7,  1,  2,  0,   0,  0,   32'hA5A5A5A5, 32'h0,        32'h0,        32'hC,        16'h0000, 0};
    v[6]  = '{0, 2,  32'h22222222, 0,  0,  0,  0,   1,  2,   32'h0,        32'h0,        32'h0,        32'hC,        16'h0004, 0};
    v[7]  = '{1, 0,  32'h0,        2,  7,  5,  0,   0,  0,   32'h22222222, 32'hA5A5A5A5, 32'h12345678, 32'hC,        16'h0004, 1};
    v[8]  = '{1, 0,  32'h0,        9,  9,  9,  0,   1,  2,   32'h0,        32'h0,        32'h0,        32'hC,        16'h0004, 0};
    v[9]  = '{0, 15, 32'h100,      15, 4,  4,  1,   0,  0,   32'h100,      32'h0,        32'h0,        32'h100,      16'h0004, 0};
    v[10] = '{0, 15, 32'hFFFFFFFC, 15, 4,  4,  0,   0,  0,   32'hFFFFFFFC, 32'h0,        32'h0,        32'hFFFFFFFC, 16'h0004, 0};
    v[11] = '{1, 0,  32'h0,        15, 4,  4,  1,   0,  0,   32'h0,        32'h0,        32'h0,        32'h0,        16'h0004, 0};
    v[12] = '{0, 3,  32'hDEADBEEF, 3,  15, 2,  1,   0,  0,   32'hDEADBEEF, 32'h4,        32'h22222222, 32'h4,        16'h0004, 1};

    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("reset_y0", y0, 32'h0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_busy", {16'h0, bz}, 32'h0);
    chk("reset_hazard", {31'h0, hz}, 32'h0);

    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      le = v[n].le; rc = v[n].rc; wd = v[n].i; ra = v[n].ra; rb = v[n].rb; rdx = v[n].rd;
      pinc = v[n].pinc; iss = v[n].iss; ird = v[n].ird;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_y0", n), y0, v[n].y0);
      chk($sformatf("v%0d_y1", n), y1, v[n].y1);
      chk($sformatf("v%0d_y2", n), y2, v[n].y2);
      chk($sformatf("v%0d_pc", n), pc, v[n].pc);
      chk($sformatf("v%0d_busy", n), {16'h0, bz}, {16'h0, v[n].bz});
      chk($sformatf("v%0d_hazard", n), {31'h0, hz}, {31'h0, v[n].hz});
    end

    // same-cycle read of the index being written
    @(negedge clk);
    le = 1'b0; rc = 4'd6; wd = 32'h66; ra = 4'd6; rb = 4'd2; rdx = 4'd2; pinc = 1'b0; iss = 1'b0;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_read", y0, 32'h66);
`else
    chk("same_cycle_read", y0, 32'h0);
`endif
    chk("same_cycle_hazard", {31'h0, hz}, 32'h1);
    @(posedge clk);
    #1;
    chk("after_write_read", y0, 32'h66);

    // asynchronous reset mid-cycle, with a write presented while it is held
    @(negedge clk);
    le = 1'b1; ra = 4'd3; rb = 4'd15;
    #1;
    chk("pre_reset_r3", y0, 32'hDEADBEEF);
    #2;
    clr = 1'b0;
    #1;
    chk("async_reset_y0", y0, 32'h0);
    chk("async_reset_pc", pc, 32'h0);
    chk("async_reset_busy", {16'h0, bz}, 32'h0);
    chk("async_reset_hazard", {31'h0, hz}, 32'h0);
    le = 1'b0; rc = 4'd3; wd = 32'h1; pinc = 1'b1;
    @(posedge clk);
    #1;
    chk("write_lost_in_reset", y0, 32'h0);
    chk("pc_held_in_reset", pc, 32'h0);
    @(negedge clk);
    le = 1'b1; pinc = 1'b0;
    clr = 1'b1;

    // reduced configuration: WIDTH=16, NREGS=8, PC_STEP=2
    @(negedge clk);
    s_le = 1'b0; s_rc = 3'd7; s_wd = 16'hFFFE; s_ra = 3'd7;
    @(posedge clk);
    #1;
    chk("s_pc_preset", {16'h0, s_pc}, 32'hFFFE);
    @(negedge clk);
    s_le = 1'b1; s_pinc = 1'b1;
    @(posedge clk);
    #1;
    chk("s_pc_wrap", {16'h0, s_pc}, 32'h0);
    chk("s_y0_pc", {16'h0, s_y0}, 32'h0);
    @(negedge clk);
    s_iss = 1'b1; s_ird = 3'd5; s_ra = 3'd5;
    @(posedge clk);
    #1;
    chk("s_pc_step", {16'h0, s_pc}, 32'h2);
    chk("s_busy", {24'h0, s_bz}, 32'h20);
    chk("s_hazard", {31'h0, s_hz}, 32'h1);
    @(negedge clk);
    s_iss = 1'b0; s_pinc = 1'b0; s_le = 1'b0; s_rc = 3'd5; s_wd = 16'hBEEF;
    @(posedge clk);
    #1;
    chk("s_busy_clear", {24'h0, s_bz}, 32'h0);
    chk("s_read", {16'h0, s_y1}, 32'hBEEF);
    s_le = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
